// File: rtl/power_mon_pkg.sv
// ---------------------------------------------------------------------------
// power_mon_pkg
// Shared types and default widths for the power-measurement stage.
//   state_e   : monitor FSM states (IDLE, PRIME, COUNT, REPORT)
//   rpt_rec_t : one report record {idx, toggles, ones, last} at default widths
// ---------------------------------------------------------------------------
package power_mon_pkg;

    localparam int DEF_NUM_NETS = 5;
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_WIN_W    = 16;
    localparam int DEF_IDX_W    = $clog2(DEF_NUM_NETS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        COUNT  = 2'd2,
        REPORT = 2'd3
    } state_e;

    typedef struct packed {
        logic [DEF_IDX_W-1:0] idx;
        logic [DEF_CNT_W-1:0] toggles;
        logic [DEF_CNT_W-1:0] ones;
        logic                 last;
    } rpt_rec_t;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// W-bit up counter with synchronous clear and enable. It holds at all-ones
// instead of wrapping.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : increment by one this cycle
//   count    : current value
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/toggle_activity_monitor.sv
// ---------------------------------------------------------------------------
// toggle_activity_monitor
// Counts per-net toggles and ones-cycles over a window of valid samples, then
// streams one record per net.
//   start/window_len       : begin a measurement (honoured in IDLE only)
//   sample_valid/sample    : per-cycle net values
//   busy                   : high in every state except IDLE
//   rpt_*                  : report record stream
//   done                   : one-cycle pulse after the last record is taken
//   dbg_state              : current FSM state
//
// Report handshake: a record transfers on a cycle where rpt_valid and
// rpt_ready are both high. Once rpt_valid rises, it and all rpt_* fields
// stay stable until that transfer; rpt_valid never depends on rpt_ready.
// ---------------------------------------------------------------------------
module toggle_activity_monitor
    import power_mon_pkg::*;
#(
    parameter int NUM_NETS = DEF_NUM_NETS,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int WIN_W    = DEF_WIN_W,
    parameter int IDX_W    = $clog2(NUM_NETS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIN_W-1:0]    window_len,
    input  logic                sample_valid,
    input  logic [NUM_NETS-1:0] sample,
    output logic                busy,
    output logic                rpt_valid,
    input  logic                rpt_ready,
    output logic [IDX_W-1:0]    rpt_idx,
    output logic [CNT_W-1:0]    rpt_toggles,
    output logic [CNT_W-1:0]    rpt_ones,
    output logic                rpt_last,
    output logic                done,
    output state_e              dbg_state
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NETS - 1);

    state_e                state;
    logic [WIN_W-1:0]      win_len_q;
    logic [WIN_W-1:0]      win_cnt;
    logic [NUM_NETS-1:0]   prev;
    logic [IDX_W-1:0]      idx_q;
    logic                  valid_q;
    logic                  done_q;

    logic                  start_ok;
    logic                  take;
    logic [NUM_NETS-1:0]   ones_en;
    logic [NUM_NETS-1:0]   tog_en;
    logic [CNT_W-1:0]      tog_cnt  [NUM_NETS];
    logic [CNT_W-1:0]      ones_cnt [NUM_NETS];

    // A start landing on the done cycle is dropped; the monitor is already
    // back in IDLE then, so done_q must be checked explicitly.
    assign start_ok = (state == IDLE) && start && !done_q;
    assign take     = sample_valid && ((state == PRIME) || (state == COUNT));
    assign ones_en  = take ? sample : '0;
    // The priming sample has no predecessor, so it never contributes toggles.
    assign tog_en   = (sample_valid && (state == COUNT)) ? (sample ^ prev) : '0;

    for (genvar g = 0; g < NUM_NETS; g++) begin : g_net
        sat_counter #(.W(CNT_W)) u_tog (
            .clk   (clk),
            .rst   (rst),
            .clr   (start_ok),
            .en    (tog_en[g]),
            .count (tog_cnt[g])
        );
        sat_counter #(.W(CNT_W)) u_ones (
            .clk   (clk),
            .rst   (rst),
            .clr   (start_ok),
            .en    (ones_en[g]),
            .count (ones_cnt[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            win_len_q <= '0;
            win_cnt   <= '0;
            prev      <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        win_len_q <= window_len;
                        win_cnt   <= '0;
                        prev      <= '0;
                        idx_q     <= '0;
                        if (window_len == '0) begin
                            state   <= REPORT;
                            valid_q <= 1'b1;
                        end else begin
                            state <= PRIME;
                        end
                    end
                end
                PRIME: begin
                    if (sample_valid) begin
                        prev    <= sample;
                        win_cnt <= WIN_W'(1);
                        if (win_len_q == WIN_W'(1)) begin
                            state   <= REPORT;
                            valid_q <= 1'b1;
                        end else begin
                            state <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (sample_valid) begin
                        prev    <= sample;
                        win_cnt <= win_cnt + WIN_W'(1);
                        // This sample is the one that reaches window_len.
                        if (win_cnt == win_len_q - WIN_W'(1)) begin
                            state   <= REPORT;
                            valid_q <= 1'b1;
                        end
                    end
                end
                REPORT: begin
                    if (valid_q && rpt_ready) begin
                        if (idx_q == LAST_IDX) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            idx_q   <= '0;
                            state   <= IDLE;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Counters are frozen in REPORT, so reading them through the registered
    // index gives stable record fields; fields read 0 whenever no record is up.
    always_comb begin
        rpt_toggles = '0;
        rpt_ones    = '0;
        for (int i = 0; i < NUM_NETS; i++) begin
            if (valid_q && (idx_q == IDX_W'(i))) begin
                rpt_toggles = tog_cnt[i];
                rpt_ones    = ones_cnt[i];
            end
        end
    end

    assign busy      = (state != IDLE);
    assign rpt_valid = valid_q;
    assign rpt_idx   = idx_q;
    assign rpt_last  = valid_q && (idx_q == LAST_IDX);
    assign done      = done_q;
    assign dbg_state = state;

endmodule
